// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith datapath plus a radix-2
// sequential divider (DIV/DIVU) that stalls the pipeline while it iterates.
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic              annul_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int SH_W  = $clog2(DATA_W);

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } div_state_e;

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;

  logic              is_div_s, is_sdiv_s;
  logic [DATA_W-1:0] mag1_s, mag2_s;
  logic [DATA_W:0]   trial_s, diff_s;
  logic              ge_s;
  logic              stall_s, whilo_s;
  logic [DATA_W-1:0] quo_fin_s, rem_fin_s;
  logic [DATA_W-1:0] logic_res_s, shift_res_s, arith_res_s, alu_res_s;
  logic [SH_W-1:0]   sh_s;

  assign is_div_s  = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_sdiv_s = (aluop_i == OP_DIV);
  assign sh_s      = reg1_i[SH_W-1:0];

  // Single-cycle result for the logic, shift and arithmetic classes
  always_comb begin
    logic_res_s = '0;
    shift_res_s = '0;
    arith_res_s = '0;
    case (aluop_i)
      OP_AND:  logic_res_s = reg1_i & reg2_i;
      OP_OR:   logic_res_s = reg1_i | reg2_i;
      OP_XOR:  logic_res_s = reg1_i ^ reg2_i;
      OP_NOR:  logic_res_s = ~(reg1_i | reg2_i);
      default: logic_res_s = '0;
    endcase
    case (aluop_i)
      OP_SLL:  shift_res_s = reg2_i << sh_s;
      OP_SRL:  shift_res_s = reg2_i >> sh_s;
      OP_SRA:  shift_res_s = DATA_W'($signed(reg2_i) >>> sh_s);
      default: shift_res_s = '0;
    endcase
    case (aluop_i)
      OP_ADDU: arith_res_s = reg1_i + reg2_i;
      OP_SUBU: arith_res_s = reg1_i - reg2_i;
      OP_SLT:  arith_res_s = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      OP_SLTU: arith_res_s = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
      default: arith_res_s = '0;
    endcase
    case (alusel_i)
      SEL_LOGIC: alu_res_s = logic_res_s;
      SEL_SHIFT: alu_res_s = shift_res_s;
      SEL_ARITH: alu_res_s = arith_res_s;
      default:   alu_res_s = '0;
    endcase
    if (is_div_s) begin
      alu_res_s = '0;
    end else begin
      alu_res_s = alu_res_s;
    end
  end

  // DIV works on magnitudes; signs are reapplied in END
  assign mag1_s = (is_sdiv_s && reg1_i[DATA_W-1]) ? (~reg1_i + 1'b1) : reg1_i;
  assign mag2_s = (is_sdiv_s && reg2_i[DATA_W-1]) ? (~reg2_i + 1'b1) : reg2_i;

  // Shift-subtract step: quo_q holds the dividend bits still to be consumed
  assign trial_s = {rem_q, quo_q[DATA_W-1]};
  assign diff_s  = trial_s - {1'b0, dvs_q};
  assign ge_s    = ~diff_s[DATA_W];

  // Divider next-state, stall and HI/LO write logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    stall_s = 1'b0;
    whilo_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_div_s) begin
          stall_s = 1'b1;
          qneg_d  = is_sdiv_s & (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
          rneg_d  = is_sdiv_s & reg1_i[DATA_W-1];
          dvs_d   = mag2_s;
          quo_d   = mag1_s;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (reg2_i == '0) ? S_DIVZERO : S_ON;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIVZERO: begin
        stall_s = 1'b1;
        quo_d   = '0;
        rem_d   = '0;
        qneg_d  = 1'b0;
        rneg_d  = 1'b0;
        state_d = S_END;
      end
      S_ON: begin
        stall_s = 1'b1;
        rem_d   = ge_s ? diff_s[DATA_W-1:0] : trial_s[DATA_W-1:0];
        quo_d   = {quo_q[DATA_W-2:0], ge_s};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = S_END;
        end else begin
          state_d = S_ON;
        end
      end
      S_END: begin
        whilo_s = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (annul_i) begin
      state_d = S_IDLE;
      stall_s = 1'b0;
      whilo_s = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Divider state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign quo_fin_s = qneg_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fin_s = rneg_q ? (~rem_q + 1'b1) : rem_q;

  // Output drive; reset forces every output low within the same cycle
  always_comb begin
    if (rst) begin
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
    end else begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = alu_res_s;
      whilo_o    = whilo_s;
      hi_o       = whilo_s ? rem_fin_s : '0;
      lo_o       = whilo_s ? quo_fin_s : '0;
      stallreq_o = stall_s;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: randomized ALU ops and divides compared
// against an arithmetic reference model, plus reset/annul/corner cases.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg, annul;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .annul_i(annul),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic we);
    aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = d; wreg = we;
  endtask

  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     sh;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    sh = int'(a[4:0]);
    case ({sel, op})
      {3'b001, 8'h24}: return a & b;
      {3'b001, 8'h25}: return a | b;
      {3'b001, 8'h26}: return a ^ b;
      {3'b001, 8'h27}: return ~(a | b);
      {3'b010, 8'h7C}: return 32'((longint'(b) * (64'sd1 <<< sh)));
      {3'b010, 8'h02}: return 32'(longint'(b) / (64'sd1 <<< sh));
      {3'b010, 8'h03}: return 32'((sb - ((sb % (64'sd1 <<< sh) + (64'sd1 <<< sh)) % (64'sd1 <<< sh))) / (64'sd1 <<< sh));
      {3'b100, 8'h21}: return 32'(longint'(a) + longint'(b));
      {3'b100, 8'h23}: return 32'(longint'(a) - longint'(b));
      {3'b100, 8'h2A}: return (sa < sb) ? 32'd1 : 32'd0;
      {3'b100, 8'h2B}: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default:         return 32'd0;
    endcase
  endfunction

  task automatic alu_op(input string tag, input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] b);
    logic [4:0] d;
    logic       we;
    d  = 5'($urandom_range(0, 31));
    we = 1'($urandom_range(0, 1));
    drive(op, sel, a, b, d, we);
    @(negedge clk);
    check_val({tag, "_wdata"}, wdata_o, ref_alu(op, sel, a, b));
    check_val({tag, "_wd"}, 32'(wd_o), 32'(d));
    check_val({tag, "_wreg"}, 32'(wreg_o), 32'(we));
    check_val({tag, "_stall"}, 32'(stallreq_o), 32'd0);
    check_val({tag, "_whilo"}, 32'(whilo_o), 32'd0);
    next_cycle();
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check_val({tag, "_wd"}, 32'(wd_o), 32'd0);
    check_val({tag, "_wreg"}, 32'(wreg_o), 32'd0);
    check_val({tag, "_wdata"}, wdata_o, 32'd0);
    check_val({tag, "_whilo"}, 32'(whilo_o), 32'd0);
    check_val({tag, "_hi"}, hi_o, 32'd0);
    check_val({tag, "_lo"}, lo_o, 32'd0);
    check_val({tag, "_stall"}, 32'(stallreq_o), 32'd0);
  endtask

  // Runs one divide to completion; leaves inputs held and time just past the END edge.
  task automatic run_div(input string tag, input logic is_signed, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    longint      sa, sb;
    int          stalls;
    if (b == 32'd0) begin
      eq = 32'd0; er = 32'd0;
    end else if (is_signed) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      eq = 32'(sa / sb);
      er = 32'(sa % sb);
    end else begin
      eq = 32'(longint'(a) / longint'(b));
      er = 32'(longint'(a) % longint'(b));
    end
    stalls = (b == 32'd0) ? 2 : 33;
    drive(is_signed ? 8'h1A : 8'h1B, 3'b000, a, b, 5'd0, 1'b0);
    for (int i = 0; i < stalls; i++) begin
      @(negedge clk);
      check_val({tag, "_stall"}, 32'(stallreq_o), 32'd1);
      check_val({tag, "_whilo_early"}, 32'(whilo_o), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check_val({tag, "_end_stall"}, 32'(stallreq_o), 32'd0);
    check_val({tag, "_whilo"}, 32'(whilo_o), 32'd1);
    check_val({tag, "_lo"}, lo_o, eq);
    check_val({tag, "_hi"}, hi_o, er);
    check_val({tag, "_wdata"}, wdata_o, 32'd0);
    next_cycle();
  endtask

  task automatic expect_idle(input string tag, input int n);
    drive(8'h00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val({tag, "_stall"}, 32'(stallreq_o), 32'd0);
      check_val({tag, "_whilo"}, 32'(whilo_o), 32'd0);
      next_cycle();
    end
  endtask

  logic [7:0] op_tab  [11] = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03,
                               8'h21, 8'h23, 8'h2A, 8'h2B};
  logic [2:0] sel_tab [11] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010,
                               3'b100, 3'b100, 3'b100, 3'b100};

  initial begin
    int k;
    logic [2:0]  sel;
    logic [31:0] a, b;
    annul = 1'b0;
    rst   = 1'b1;
    drive(8'h1A, 3'b000, 32'd100, 32'd7, 5'd3, 1'b1);
    check_all_zero("rst0");
    next_cycle();
    check_all_zero("rst1");
    next_cycle();
    rst = 1'b0;
    expect_idle("post_rst", 3);

    alu_op("or",   8'h25, 3'b001, 32'h0000FF00, 32'h00FF0000);
    alu_op("subu", 8'h23, 3'b100, 32'h00000000, 32'h00000001);
    alu_op("slt",  8'h2A, 3'b100, 32'hFFFFFFFF, 32'h00000001);
    alu_op("sltu", 8'h2B, 3'b100, 32'hFFFFFFFF, 32'h00000001);
    alu_op("sra",  8'h03, 3'b010, 32'h00000004, 32'h80000000);
    alu_op("badsel", 8'h21, 3'b111, 32'h12345678, 32'h11111111);

    for (int i = 0; i < 300; i++) begin
      k   = $urandom_range(0, 10);
      sel = ($urandom_range(0, 9) == 0) ? 3'b011 : sel_tab[k];
      a   = $urandom();
      b   = ($urandom_range(0, 3) == 0) ? 32'h80000000 | $urandom() : $urandom();
      if ($urandom_range(0, 3) == 0) a = b;
      alu_op("rnd_alu", op_tab[k], sel, a, b);
    end

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
    expect_idle("after_divu", 2);
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE);
    run_div("divu_zero", 1'b0, 32'd12345, 32'd0);
    run_div("div_zero", 1'b1, 32'hFFFF0000, 32'd0);
    run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);
    expect_idle("after_ovf", 1);

    for (int i = 0; i < 30; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom() >> $urandom_range(0, 31));
      run_div("rnd_div", 1'($urandom_range(0, 1)), a, b);
    end

    // Abort on the tenth ON cycle
    drive(8'h1B, 3'b000, 32'd1000, 32'd3, 5'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("abort_pre_stall", 32'(stallreq_o), 32'd1);
      next_cycle();
    end
    annul = 1'b1;
    @(negedge clk);
    check_val("abort_stall", 32'(stallreq_o), 32'd0);
    check_val("abort_whilo", 32'(whilo_o), 32'd0);
    next_cycle();
    annul = 1'b0;
    expect_idle("abort_after", 40);
    run_div("post_abort", 1'b0, 32'd1000, 32'd3);

    // Reset mid-divide
    drive(8'h1A, 3'b000, 32'hFFFFF000, 32'd9, 5'd7, 1'b0);
    for (int i = 0; i < 15; i++) next_cycle();
    rst = 1'b1;
    check_all_zero("midrst");
    next_cycle();
    rst = 1'b0;
    expect_idle("midrst_after", 40);
    run_div("post_rst_div", 1'b1, 32'hFFFFF000, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits directly downstream of the ID/EX pipeline register and upstream of the EX/MEM register.
- Consumes the decoded ALU op/select, both operands and the destination info. Produces the register write-back data plus HI/LO write requests.
- Integer ops are single-cycle. DIV/DIVU use a 32-iteration radix-2 sequential divider that stalls the pipeline through a stall request.

Parameters:
- DATA_W, 32, operand/result width; the divider iteration count equals DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- aluop_i  in  8  ALU sub-op
- alusel_i  in  3  result class
- reg1_i  in  DATA_W  operand 1 (shift amount in [4:0] for shifts)
- reg2_i  in  DATA_W  operand 2
- wd_i  in  5  destination register address
- wreg_i  in  1  write-enable from decode
- annul_i  in  1  flush; aborts an in-flight divide
- wd_o  out  5  destination address to EX/MEM
- wreg_o  out  1  register write enable to EX/MEM
- wdata_o  out  DATA_W  register write data
- whilo_o  out  1  HI/LO write enable
- hi_o  out  DATA_W  HI write data (remainder)
- lo_o  out  DATA_W  LO write data (quotient)
- stallreq_o  out  1  stall request to pipeline control

Behaviour:
- Op encoding (8-bit aluop):
  - Logic: AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - Shift: SLL 0x7C, SRL 0x02, SRA 0x03.
  - Arithmetic: ADDU 0x21, SUBU 0x23, SLT 0x2A, SLTU 0x2B.
  - Divide: DIV 0x1A, DIVU 0x1B.
  - NOP 0x00.
- alusel (3-bit): NOP 000, LOGIC 001, SHIFT 010, ARITH 100.
- Single-cycle datapath is combinational from the inputs:
  - wd_o = wd_i, wreg_o = wreg_i.
  - wdata_o is selected by alusel_i; an unknown alusel gives 0.
  - ADDU/SUBU wrap modulo 2^32; no overflow trap.
  - SLT is a signed compare, SLTU unsigned; result is 1 or 0.
  - Shift amount is reg1_i[4:0] applied to reg2_i; SRA sign-fills.
- While rst=1, every output is 0, including stallreq_o and whilo_o.
- Divider FSM states: IDLE, DIVZERO, ON, END. The FSM resets to IDLE, clears the counter, and drops any in-flight divide.
- IDLE:
  - aluop_i in {DIV, DIVU} and annul_i=0 → latch the operands.
  - DIV converts each operand to its magnitude and records the quotient and remainder signs.
  - reg2_i==0 → go to DIVZERO; otherwise go to ON with counter=0.
  - stallreq_o=1 in this cycle.
- ON: one shift-subtract step per cycle, counter increments. After step 31 (counter==31) → END. stallreq_o=1 throughout.
- DIVZERO: quotient=0, remainder=0 → END. stallreq_o=1.
- END:
  - Apply signs for DIV: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - lo_o=quotient, hi_o=remainder, whilo_o=1, stallreq_o=0.
  - Next cycle → IDLE unconditionally.
- Latency: a divide asserts stallreq_o for 33 cycles (IDLE+32 ON). The result appears on cycle 34 relative to the op's first EX cycle.
  - Divide by zero: 2 stall cycles, result on cycle 3.
- A back-to-back divide starts from IDLE in the cycle after END.
- annul_i=1 in any state → IDLE next cycle. stallreq_o=0 and whilo_o=0 in that cycle. No HI/LO write occurs for the aborted divide.
- The inputs are held stable by the upstream register during the stall. The divider uses only its latched operands.
- Divide ops drive wdata_o=0; their wreg_i is 0 from decode.
- whilo_o=0 outside END. hi_o and lo_o are 0 when whilo_o=0.
- Signed corner case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no trap.

Test Plan:
- Reset: hold rst for 2 cycles with DIV presented → all outputs 0; after release the FSM is in IDLE and stallreq_o=0 until an op is sampled.
- ALU ops: OR 0x0000FF00|0x00FF0000 → 0x00FFFF00; SUBU 0 − 1 → 0xFFFFFFFF; SLT −1<1 → 1; SLTU 0xFFFFFFFF<1 → 0; SRA 0x80000000 by 4 → 0xF8000000. wd_o and wreg_o pass through.
- DIVU 100/7 → stallreq_o high for exactly 33 cycles; on cycle 34 whilo_o=1, lo=14, hi=2; IDLE the following cycle.
- DIV −7/2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Back-to-back DIV 7/−2 → lo=−3, hi=1, with no extra bubble beyond the stall.
- DIVU x/0 → 2 stall cycles, then whilo_o=1, hi=lo=0.
- Abort: assert annul_i on ON cycle 10 → IDLE next cycle, whilo_o never asserted. Separately, assert rst mid-divide → IDLE and all outputs 0.
